sha_sequencer: RTL and testbench
================================

SHA_SEQUENCER -- requirements
Module: sha_sequencer

Interface
Parameters: none.
REQ-001 Clock and reset: one clock, clk; reset is synchronous and active-high, named reset.
REQ-002 clk  input  1  block clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request one 64-round compression; sampled only when ready=1.
REQ-005 ready  output  1  high in IDLE and FINAL; start is accepted only when ready=1.
REQ-006 busy  output  1  high in RUN and FINAL.
REQ-007 H1  input  256  combinational result from the downstream round unit; {a..h}, a in [255:224].
REQ-008 round  output  6  registered round index to the downstream round unit.
REQ-009 Kt  output  32  registered round constant; Kt lags round by one cycle, so it is aligned with the unit's registered Wt.
REQ-010 digest  output  256  captured H1; held until the next capture.
REQ-011 digest_valid  output  1  one-cycle pulse marking a new digest.

Function
REQ-012 The FSM has states IDLE, RUN and FINAL.
REQ-013 In IDLE, round=0 is driven continuously, so the downstream unit reloads H0 every cycle.
REQ-014 IDLE transitions: on start=1, go to RUN and set round<=1; otherwise hold.
REQ-015 The edge at which start is accepted is the round-0 issue edge: the unit samples round=0 on that edge.
REQ-016 RUN increments round by 1 per edge.
REQ-017 RUN transitions: on the edge that samples round=63, go to FINAL and set round<=0.
REQ-018 During FINAL, H1 is the completed 64-round result.
REQ-019 On the FINAL exit edge: digest<=H1 and digest_valid<=1 for exactly one cycle.
REQ-020 FINAL exit target: if start=1, go to RUN with round<=1 (back-to-back, one block per 64 cycles); otherwise go to IDLE.
REQ-021 Kt<=K[round] on every edge, regardless of state, where K is the 64-entry FIPS 180-4 SHA-256 constant table held in an internal ROM.
REQ-022 Latency: digest_valid is high 64 cycles after the cycle in which start was accepted.
REQ-023 Upstream obligation: M and H0 at the round unit stay stable from start acceptance through the FINAL capture edge; this block does not check it.
REQ-024 start while busy=1 and ready=0 (RUN) is ignored; it is not queued.
REQ-025 Round wrap: round never exceeds 63; no 6-bit overflow path is permitted.

Reset
REQ-026 reset=1 at an edge forces: state IDLE, round=0, Kt=0, digest=0, digest_valid=0, busy=0, ready=1.
REQ-027 reset takes priority over start.
REQ-028 reset mid-RUN or in FINAL aborts the block: no digest_valid is produced and digest keeps 0 (the reset value).
REQ-029 After reset release, the first edge sets Kt=0x428a2f98.

Verification
REQ-030 Hold start low after reset -> round stays 0, Kt=0x428a2f98 from the second cycle on, busy=0, digest_valid never asserted.
REQ-031 Single start pulse -> round sequence 1..63, then 0; Kt tracks K[round-1] (e.g. 0x71374491 while round=2, 0xc67178f2 while round=0 in FINAL); digest_valid exactly 64 cycles after the start cycle.
REQ-032 System check with the round unit: "abc" padded block and standard H0 -> digest=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
REQ-033 start held high continuously -> digest_valid pulses every 64 cycles, and two different messages swapped at each FINAL produce both correct digests.
REQ-034 start asserted in RUN at round=10 -> ignored; the round sequence is unaffected and exactly one digest_valid results.
REQ-035 reset at round=40 -> next cycle round=0, busy=0, digest_valid=0, digest=0; a subsequent start completes normally.

Source files
------------

// File: rtl/sha_sequencer.sv
// Round sequencer for a SHA-256 compression unit: issues round indices and the
// matching round constants, then captures the finished hash state as the digest.
module sha_sequencer (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    output logic         ready,
    output logic         busy,
    input  logic [255:0] H1,
    output logic [5:0]   round,
    output logic [31:0]  Kt,
    output logic [255:0] digest,
    output logic         digest_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FINAL = 2'd2
    } state_e;

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    state_e         state_q, state_d;
    logic [5:0]     round_q, round_d;
    logic [31:0]    kt_q, kt_d;
    logic [255:0]   digest_q, digest_d;
    logic           valid_q, valid_d;

    // Handshake: start is taken on a rising edge only while ready=1; there is
    // no queueing, so a start seen while ready=0 is simply dropped.
    always_comb begin
        state_d  = state_q;
        round_d  = round_q;
        kt_d     = K_TAB[round_q];
        digest_d = digest_q;
        valid_d  = 1'b0;
        ready    = (state_q == IDLE) || (state_q == FINAL);
        busy     = (state_q == RUN) || (state_q == FINAL);

        case (state_q)
            IDLE: begin
                round_d = 6'd0;
                if (start) begin
                    state_d = RUN;
                    round_d = 6'd1;
                end
            end
            RUN: begin
                // Wrap to 0 explicitly at 63 so the counter never overflows.
                if (round_q == 6'd63) begin
                    state_d = FINAL;
                    round_d = 6'd0;
                end else begin
                    round_d = round_q + 6'd1;
                end
            end
            FINAL: begin
                digest_d = H1;
                valid_d  = 1'b1;
                if (start) begin
                    state_d = RUN;
                    round_d = 6'd1;
                end else begin
                    state_d = IDLE;
                    round_d = 6'd0;
                end
            end
            default: begin
                state_d = IDLE;
                round_d = 6'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            round_q  <= 6'd0;
            kt_q     <= 32'd0;
            digest_q <= 256'd0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            round_q  <= round_d;
            kt_q     <= kt_d;
            digest_q <= digest_d;
            valid_q  <= valid_d;
        end
    end

    assign round        = round_q;
    assign Kt           = kt_q;
    assign digest       = digest_q;
    assign digest_valid = valid_q;

endmodule

// File: tb/tb_sha_sequencer.sv
// Bench for sha_sequencer: a behavioural SHA-256 round unit closes the loop, and a
// block-position model with a queue of known digests predicts every output.
module tb_sha_sequencer;

    logic         clk;
    logic         reset;
    logic         start;
    logic         ready;
    logic         busy;
    logic [255:0] H1;
    logic [5:0]   round;
    logic [31:0]  Kt;
    logic [255:0] digest;
    logic         digest_valid;

    sha_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .ready        (ready),
        .busy         (busy),
        .H1           (H1),
        .round        (round),
        .Kt           (Kt),
        .digest       (digest),
        .digest_valid (digest_valid)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference constants ----------------
    logic [31:0] k_tab [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    logic [255:0] h0 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    // Message 0 is "abc", message 1 is the empty string.
    logic [255:0] dig_lit [2] = '{
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad,
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855
    };
    logic [31:0] w_tab [2][64];

    // ---------------- SHA-256 helpers ----------------
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_round(input logic [255:0] s,
                                               input logic [31:0] w,
                                               input logic [31:0] k);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = x[i*32 +: 32] + y[i*32 +: 32];
        return r;
    endfunction

    task automatic build_sched(input int idx, input logic [31:0] m0, input logic [31:0] m15);
        logic [31:0] s0, s1;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) begin
                w_tab[idx][t] = (t == 0) ? m0 : ((t == 15) ? m15 : 32'd0);
            end else begin
                s0 = rotr(w_tab[idx][t-15], 7) ^ rotr(w_tab[idx][t-15], 18) ^ (w_tab[idx][t-15] >> 3);
                s1 = rotr(w_tab[idx][t-2], 17) ^ rotr(w_tab[idx][t-2], 19) ^ (w_tab[idx][t-2] >> 10);
                w_tab[idx][t] = s1 + w_tab[idx][t-7] + s0 + w_tab[idx][t-16];
            end
        end
    endtask

    // ---------------- downstream round unit ----------------
    logic [255:0] u_st;
    logic [31:0]  u_w;
    int           msel;

    always @(posedge clk) begin
        if (round == 6'd0) begin
            u_st <= h0;
            u_w  <= w_tab[msel][0];
        end else begin
            u_st <= sha_round(u_st, u_w, Kt);
            u_w  <= w_tab[msel][round];
        end
    end

    always_comb H1 = add8(h0, sha_round(u_st, u_w, Kt));

    // ---------------- model and scoreboard ----------------
    int            n_checks;
    int            n_err;
    int            m_pos;      // -1 idle, 1..63 = round in flight, 64 = final cycle
    logic [31:0]   m_kt;
    logic          m_valid;
    logic [255:0]  m_digest;
    logic [255:0]  exp_q[$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_round();
        return (m_pos >= 1 && m_pos <= 63) ? m_pos : 0;
    endfunction

    // One clock cycle: drive inputs, predict the post-edge outputs, compare at negedge.
    task automatic step(input logic st, input logic rst, input int ms);
        start = st;
        reset = rst;
        if (rst) begin
            m_pos    = -1;
            m_kt     = 32'd0;
            m_valid  = 1'b0;
            m_digest = 256'd0;
            exp_q.delete();
        end else begin
            m_kt    = k_tab[m_round()];
            m_valid = (m_pos == 64);
            if (m_pos == 64 && exp_q.size() > 0) m_digest = exp_q.pop_front();
            if ((m_pos == -1 || m_pos == 64) && st) begin
                m_pos = 1;
                msel  = ms;
                exp_q.push_back(dig_lit[ms]);
            end else if (m_pos >= 1 && m_pos <= 63) begin
                m_pos++;
            end else if (m_pos == 64) begin
                m_pos = -1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("round", {250'd0, round}, 256'(m_round()));
        chk("kt", {224'd0, Kt}, {224'd0, m_kt});
        chk("ready", {255'd0, ready}, {255'd0, (m_pos == -1 || m_pos == 64)});
        chk("busy", {255'd0, busy}, {255'd0, (m_pos >= 1)});
        chk("digest_valid", {255'd0, digest_valid}, {255'd0, m_valid});
        chk("digest", digest, m_digest);
        if (m_pos == 2)  chk("kt_round2", {224'd0, Kt}, 256'h71374491);
        if (m_pos == 64) chk("kt_final", {224'd0, Kt}, 256'hc67178f2);
    endtask

    // ---------------- stimulus ----------------
    int lat;
    int vcnt;

    initial begin
        n_checks = 0;
        n_err    = 0;
        start    = 1'b0;
        reset    = 1'b1;
        msel     = 0;
        m_pos    = -1;
        build_sched(0, 32'h61626380, 32'h00000018);
        build_sched(1, 32'h80000000, 32'h00000000);

        // reset state, then idle with start low
        step(0, 1, 0);
        step(0, 1, 0);
        chk("rst_kt", {224'd0, Kt}, 256'd0);
        chk("rst_ready", {255'd0, ready}, 256'd1);
        vcnt = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0);
            if (digest_valid === 1'b1) vcnt++;
        end
        chk("idle_kt", {224'd0, Kt}, 256'h428a2f98);
        chk("idle_round", {250'd0, round}, 256'd0);
        chk("idle_valids", 256'(vcnt), 256'd0);

        // single "abc" block: latency and digest literal
        step(1, 0, 0);
        lat = -1;
        for (int i = 1; i <= 70; i++) begin
            step(0, 0, 0);
            if (digest_valid === 1'b1 && lat < 0) lat = i;
        end
        chk("latency", 256'(lat), 256'd64);
        chk("abc_digest", digest, dig_lit[0]);

        // start held high, messages alternating per block
        vcnt = 0;
        for (int i = 0; i < 200; i++) begin
            step(1, 0, (m_pos == 64) ? 1 - msel : 0);
            if (digest_valid === 1'b1) vcnt++;
        end
        chk("b2b_valids", 256'(vcnt), 256'd3);
        for (int i = 0; i < 70; i++) step(0, 0, 0);

        // start asserted at round 10 is ignored
        step(1, 0, 1);
        vcnt = 0;
        for (int i = 0; i < 80; i++) begin
            step((m_pos == 10) ? 1'b1 : 1'b0, 0, 0);
            if (digest_valid === 1'b1) vcnt++;
        end
        chk("ignore_valids", 256'(vcnt), 256'd1);
        chk("empty_digest", digest, dig_lit[1]);

        // reset at round 40 aborts, then a normal block
        step(1, 0, 0);
        while (m_pos != 40) step(0, 0, 0);
        step(0, 1, 0);
        chk("abort_round", {250'd0, round}, 256'd0);
        chk("abort_busy", {255'd0, busy}, 256'd0);
        chk("abort_digest", digest, 256'd0);
        step(1, 0, 0);
        for (int i = 0; i < 70; i++) step(0, 0, 0);
        chk("after_abort_digest", digest, dig_lit[0]);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 249) == 0) ? 1'b1 : 1'b0,
                 int'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
